timer_irq_device: RTL

- Memory-mapped timer/counter peripheral on the CPU data bus. It responds to the CPU's word-address, byte-enable and write-data stores, and returns read data combinationally.
- It is the source end of the CPU `interrupt` input: it raises `irq` when a programmed countdown expires.
- It sits behind the system bridge alongside DM. The bridge decodes the base address and presents the device-relative offset plus gated byte-enables.

---
 rtl/timer_irq_device_pkg.sv | 32 +++
 rtl/timer_irq_device_byte_merge.sv | 19 +
 rtl/timer_irq_device.sv | 108 ++++++++++
 3 files changed

// File: rtl/timer_irq_device_pkg.sv
// Shared definitions for the timer/interrupt device, its bridge and bench.
// Register offsets, CTRL bit positions, MODE codes and FSM states.
package timer_irq_device_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_W    = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  typedef enum logic [1:0] {
    R_CTRL,
    R_PRESET,
    R_COUNT,
    R_RSVD
  } reg_sel_t;

endpackage

// File: rtl/timer_irq_device_byte_merge.sv
// Lane merge of old and new 32-bit words under byte-enables.
// Also used by the bridge for data-memory stores.
module byte_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  byteen,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_data;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) begin
        merged[8*i +: 8] = new_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/timer_irq_device.sv
// Memory-mapped countdown timer raising a registered interrupt on expiry.
// One-shot and auto-reload modes; combinational register reads.
module timer_irq_device
  import timer_irq_device_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count;
  state_t            state;
  logic              irq_flag;

  reg_sel_t    sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic [1:0]  mode;
  logic [31:0] merged;
  logic        unused_ok;

  assign sel       = reg_sel_t'(addr[3:2]);
  assign wr_ctrl   = (|byteen) && (sel == R_CTRL);
  assign wr_preset = (|byteen) && (sel == R_PRESET);
  assign en        = ctrl[CTRL_EN];
  assign mode      = ctrl[CTRL_MODE +: 2];
  assign unused_ok = ^addr[1:0];

  always_comb begin
    rdata = '0;
    unique case (sel)
      R_CTRL:   rdata = 32'(ctrl);
      R_PRESET: rdata = 32'(preset);
      R_COUNT:  rdata = 32'(count);
      default:  rdata = '0;
    endcase
  end

  // The read mux already selects the old value of the addressed register.
  byte_merge u_merge (
    .old_data (rdata),
    .new_data (wdata),
    .byteen   (byteen),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      state    <= S_IDLE;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= ctrl[CTRL_IM] & irq_flag;
      if (wr_preset) begin
        preset <= merged[CNT_W-1:0];
      end
      if (wr_ctrl) begin
        ctrl     <= merged[CTRL_W-1:0];
        irq_flag <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (en) state <= S_LOAD;
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (count > ONE) begin
            count <= count - ONE;
          end else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= S_INT;
          end
        end
        S_INT: begin
          state <= S_IDLE;
          // A software CTRL write in this cycle keeps its own EN value.
          if (mode == MODE_RELOAD) begin
            irq_flag <= 1'b0;
          end else if (!wr_ctrl) begin
            ctrl[CTRL_EN] <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
